// File: rtl/matrix_stream_loader.sv
// Stream-to-operand loader for matrix_mult_parallel_flat: size word, then A and B row-major, then a two-cycle enable burst.
// Optional MATRIX_LOADER_SIZE_ERR_EN rejects out-of-range size words with a size_err pulse instead of clamping them.
module matrix_stream_loader #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    output logic [31:0]                            matrix_size,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B,
    output logic                                   enable,
    output logic                                   busy,
`ifdef MATRIX_LOADER_SIZE_ERR_EN
    output logic                                   size_err,
`endif
    output logic                                   c_valid
);

    localparam int CW = $clog2(MAX_SIZE + 1);
    localparam int VW = MAX_SIZE * MAX_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_FIRE   = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   last_q;
    logic [31:0]     size_q;
    logic [VW-1:0]   a_q;
    logic [VW-1:0]   b_q;
    logic            enable_q;
    logic            busy_q;
    logic            ready_q;
    logic            c_valid_q;
    logic            fire_cnt_q;
`ifdef MATRIX_LOADER_SIZE_ERR_EN
    logic            size_err_q;
`endif

    logic            accept_s;
    logic            last_elem_s;
    logic            row_end_s;
    logic            size_bad_s;
    logic [CW-1:0]   size_n_s;
    int              base_s;

    function automatic logic [CW-1:0] clamp_size(input logic [DATA_WIDTH-1:0] v);
        if (v == {DATA_WIDTH{1'b0}}) begin
            return CW'(1);
        end else if (v > DATA_WIDTH'(MAX_SIZE)) begin
            return CW'(MAX_SIZE);
        end else begin
            return v[CW-1:0];
        end
    endfunction

    function automatic int elem_base(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return ((int'(r) * MAX_SIZE) + int'(c)) * DATA_WIDTH;
    endfunction

    assign accept_s    = s_valid & ready_q;
    assign row_end_s   = (col_q == last_q);
    assign last_elem_s = row_end_s && (row_q == last_q);
    assign size_bad_s  = (s_data == {DATA_WIDTH{1'b0}}) || (s_data > DATA_WIDTH'(MAX_SIZE));
    assign size_n_s    = clamp_size(s_data);
    assign base_s      = elem_base(row_q, col_q);

    // Loader FSM: size capture, element placement, and the two-cycle enable burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            last_q     <= '0;
            size_q     <= 32'd1;
            a_q        <= '0;
            b_q        <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            c_valid_q  <= 1'b0;
            fire_cnt_q <= 1'b0;
`ifdef MATRIX_LOADER_SIZE_ERR_EN
            size_err_q <= 1'b0;
`endif
        end else begin
            c_valid_q <= 1'b0;
`ifdef MATRIX_LOADER_SIZE_ERR_EN
            size_err_q <= 1'b0;
`endif
            // Row-major walk over the n x n window shared by both operand loads.
            if (accept_s && (state_q == ST_LOAD_A || state_q == ST_LOAD_B)) begin
                if (last_elem_s) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (row_end_s) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef MATRIX_LOADER_SIZE_ERR_EN
                        if (size_bad_s) begin
                            size_err_q <= 1'b1;
                        end else begin
                            size_q  <= 32'(size_n_s);
                            last_q  <= size_n_s - CW'(1);
                            a_q     <= '0;
                            b_q     <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_LOAD_A;
                        end
`else
                        size_q  <= 32'(size_n_s);
                        last_q  <= size_n_s - CW'(1);
                        a_q     <= '0;
                        b_q     <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD_A;
`endif
                    end
                end
                ST_LOAD_A: begin
                    if (accept_s) begin
                        a_q[base_s +: DATA_WIDTH] <= s_data;
                        if (last_elem_s) begin
                            state_q <= ST_LOAD_B;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept_s) begin
                        b_q[base_s +: DATA_WIDTH] <= s_data;
                        if (last_elem_s) begin
                            state_q    <= ST_FIRE;
                            ready_q    <= 1'b0;
                            enable_q   <= 1'b1;
                            fire_cnt_q <= 1'b0;
                        end
                    end
                end
                ST_FIRE: begin
                    // First enabled edge latches operands, second latches C.
                    if (!fire_cnt_q) begin
                        fire_cnt_q <= 1'b1;
                    end else begin
                        fire_cnt_q <= 1'b0;
                        enable_q   <= 1'b0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        c_valid_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    enable_q <= 1'b0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = ready_q;
    assign matrix_size = size_q;
    assign A           = a_q;
    assign B           = b_q;
    assign enable      = enable_q;
    assign busy        = busy_q;
    assign c_valid     = c_valid_q;
`ifdef MATRIX_LOADER_SIZE_ERR_EN
    assign size_err    = size_err_q;
`else
    logic unused_s;
    assign unused_s = size_bad_s;
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader; C is formed from the loader's A/B outputs and checked against hand values.
module tb_matrix_stream_loader;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = 32'd0;
    logic          s_ready;
    logic [31:0]   matrix_size;
    logic [3199:0] a_s;
    logic [3199:0] b_s;
    logic          enable;
    logic          busy;
    logic          c_valid;
`ifdef MATRIX_LOADER_SIZE_ERR_EN
    logic          size_err;
`endif

    int total = 0;
    int bad = 0;
    logic [3199:0] exp_a;
    logic [3199:0] exp_b;

    matrix_stream_loader #(.MAX_SIZE(10), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .matrix_size (matrix_size),
        .A           (a_s),
        .B           (b_s),
        .enable      (enable),
        .busy        (busy),
`ifdef MATRIX_LOADER_SIZE_ERR_EN
        .size_err    (size_err),
`endif
        .c_valid     (c_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] a_el(input int r, input int c);
        return 64'(a_s[((r * 10 + c) * 32) +: 32]);
    endfunction

    function automatic logic [63:0] b_el(input int r, input int c);
        return 64'(b_s[((r * 10 + c) * 32) +: 32]);
    endfunction

    function automatic logic [63:0] c_el(input int i, input int j);
        logic [63:0] acc = 64'd0;
        for (int k = 0; k < 10; k++) acc += a_el(i, k) * b_el(k, j);
        return acc;
    endfunction

    // Called and returning at a falling edge; leaves s_valid high so pushes chain gap-free.
    task automatic push(input logic [31:0] d);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $error("FAIL push_timeout observed=%0d expected=%0d", s_ready, 1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gap_push(input logic [31:0] d);
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(d);
    endtask

    task automatic wait_cvalid(input string tag);
        int g = 0;
        s_valid = 1'b0;
        while (!c_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_cvalid"}, 64'(c_valid), 64'd1);
    endtask

    task automatic load2(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
        push(32'd2);
        push(32'(a0)); push(32'(a1)); push(32'(a2)); push(32'(a3));
        push(32'(b0)); push(32'(b1)); push(32'(b2)); push(32'(b3));
        s_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] rest;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_size", 64'(matrix_size), 64'd1);
        check("rst_A_zero", 64'(a_s == '0), 64'd1);
        check("rst_enable", 64'(enable), 64'd0);
        check("rst_cvalid", 64'(c_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Size 2 gap-free with cycle-exact enable/c_valid timing.
        push(32'd2);
        check("t1_size", 64'(matrix_size), 64'd2);
        check("t1_busy", 64'(busy), 64'd1);
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        push(32'd5); push(32'd6); push(32'd7);
        check("t1_no_early_en", 64'(enable), 64'd0);
        push(32'd8);
        s_valid = 1'b0;
        check("t1_en_c1", 64'(enable), 64'd1);
        check("t1_ready_fire", 64'(s_ready), 64'd0);
        check("t1_cv_c1", 64'(c_valid), 64'd0);
        @(negedge clk);
        check("t1_en_c2", 64'(enable), 64'd1);
        check("t1_cv_c2", 64'(c_valid), 64'd0);
        @(negedge clk);
        check("t1_en_c3", 64'(enable), 64'd0);
        check("t1_cv_c3", 64'(c_valid), 64'd1);
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_A10", 64'(a_el(1, 0)), 64'd3);
        check("t1_B11", 64'(b_el(1, 1)), 64'd8);
        check("t1_C00", c_el(0, 0), 64'd19);
        check("t1_C01", c_el(0, 1), 64'd22);
        check("t1_C10", c_el(1, 0), 64'd43);
        check("t1_C11", c_el(1, 1), 64'd50);
        rest = 64'd0;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                if (i >= 2 || j >= 2) rest += c_el(i, j);
        check("t1_C_rest", rest, 64'd0);
        @(negedge clk);
        check("t1_cv_pulse", 64'(c_valid), 64'd0);

        // Size 3 with random stalls.
        exp_a = '0;
        exp_b = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                exp_a[((r * 10 + c) * 32) +: 32] = 32'(r * 3 + c + 1);
                exp_b[((r * 10 + c) * 32) +: 32] = 32'(r * 3 + c + 10);
            end
        gap_push(32'd3);
        for (int i = 1; i <= 9; i++) gap_push(32'(i));
        for (int i = 10; i <= 18; i++) begin
            gap_push(32'(i));
            if (i < 18) check("t2_no_early_en", 64'(enable), 64'd0);
        end
        s_valid = 1'b0;
        check("t2_en", 64'(enable), 64'd1);
        check("t2_A_layout", 64'(a_s === exp_a), 64'd1);
        check("t2_B_layout", 64'(b_s === exp_b), 64'd1);
        wait_cvalid("t2");
        check("t2_C00", c_el(0, 0), 64'd84);
        check("t2_C10", c_el(1, 0), 64'd201);
        check("t2_C22", c_el(2, 2), 64'd366);

`ifndef MATRIX_LOADER_SIZE_ERR_EN
        // Oversize and zero size words clamp.
        push(32'd15);
        check("t3_clamp_hi", 64'(matrix_size), 64'd10);
        for (int i = 0; i < 200; i++) push((i < 100) ? 32'(i + 1) : 32'd1);
        s_valid = 1'b0;
        check("t3_en", 64'(enable), 64'd1);
        check("t3_A99", a_el(9, 9), 64'd100);
        check("t3_B99", b_el(9, 9), 64'd1);
        wait_cvalid("t3");
        check("t3_C00", c_el(0, 0), 64'd55);
        check("t3_C99", c_el(9, 9), 64'd955);
        push(32'd0);
        check("t3_clamp_lo", 64'(matrix_size), 64'd1);
        push(32'd7);
        push(32'd6);
        s_valid = 1'b0;
        check("t3_en_n1", 64'(enable), 64'd1);
        check("t3_A99_clr", a_el(9, 9), 64'd0);
        wait_cvalid("t3b");
        check("t3_C00_n1", c_el(0, 0), 64'd42);
        check("t3_C01_n1", c_el(0, 1), 64'd0);
`else
        // Rejected size word leaves the previous operands in place.
        push(32'd0);
        s_valid = 1'b0;
        check("te_err", 64'(size_err), 64'd1);
        check("te_busy", 64'(busy), 64'd0);
        check("te_size", 64'(matrix_size), 64'd3);
        check("te_A_kept", 64'(a_s === exp_a), 64'd1);
        check("te_B_kept", 64'(b_s === exp_b), 64'd1);
        @(negedge clk);
        check("te_err_pulse", 64'(size_err), 64'd0);
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        wait_cvalid("te");
        check("te_C11", c_el(1, 1), 64'd50);
`endif

        // Asynchronous reset part-way through A.
        push(32'd2);
        push(32'd1); push(32'd2); push(32'd3);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("tr_A_zero", 64'(a_s == '0), 64'd1);
        check("tr_busy", 64'(busy), 64'd0);
        check("tr_size", 64'(matrix_size), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tr_no_en", 64'(enable), 64'd0);
            check("tr_no_cv", 64'(c_valid), 64'd0);
        end
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        wait_cvalid("tr");
        check("tr_C01", c_el(0, 1), 64'd22);
        check("tr_C11", c_el(1, 1), 64'd50);

        // Back-to-back: next size word offered in the c_valid cycle.
        push(32'd2);
        check("tb_busy", 64'(busy), 64'd1);
        check("tb_A_clr", 64'(a_s == '0), 64'd1);
        check("tb_cv_low", 64'(c_valid), 64'd0);
        push(32'd2); push(32'd0); push(32'd0); push(32'd2);
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        wait_cvalid("tb");
        check("tb_C00", c_el(0, 0), 64'd2);
        check("tb_C10", c_el(1, 0), 64'd6);
        check("tb_C11", c_el(1, 1), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for matrix_mult_parallel_flat.
- Accepts a word stream over a valid/ready handshake: one size word, then A row-major, then B row-major.
- Assembles the flattened A and B buffers plus matrix_size, then drives the multiplier's enable for exactly two cycles so that C is registered with the new result.
- Pulses c_valid when the multiplier's C output holds the result for the loaded operands.

Parameters:
- MAX_SIZE, 10, maximum matrix dimension; must match the multiplier.
- DATA_WIDTH, 32, element width; must match the multiplier.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  stream word valid
- s_ready  output  1  loader can accept a word
- s_data  input  DATA_WIDTH  stream word (size word or element)
- matrix_size  output  32  effective size to multiplier
- A  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A to multiplier
- B  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened B to multiplier
- enable  output  1  multiplier enable
- busy  output  1  high in any state other than IDLE
- c_valid  output  1  one-cycle pulse: multiplier C now holds the result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, A=0, B=0, matrix_size=1, enable=0, c_valid=0, row/col counters=0. Reset mid-load or mid-FIRE abandons the transaction with no c_valid.
- Transfer rule: a word is accepted on a rising edge where s_valid and s_ready are both 1.
- s_ready: 1 in IDLE, LOAD_A and LOAD_B; 0 in FIRE.
- IDLE:
  - On an accepted word, take it as the size. n = s_data, clamped to [1, MAX_SIZE]; 0 maps to 1, >MAX_SIZE maps to MAX_SIZE.
  - Register n into matrix_size. Clear A and B to all zeros on the same edge.
  - Reset row=col=0, go to LOAD_A.
- LOAD_A:
  - Each accepted word is written to A[((row*MAX_SIZE+col)*DATA_WIDTH) +: DATA_WIDTH].
  - col increments; at col==n-1 it wraps to 0 and row increments.
  - The word with row==n-1 and col==n-1 resets the counters and moves the FSM to LOAD_B.
  - Positions with row>=n or col>=n stay zero.
- LOAD_B: same as LOAD_A but writes B. The last element moves the FSM to FIRE with fire_cnt=0.
- FIRE:
  - enable=1 for exactly two consecutive cycles. The first edge registers the operands in the multiplier; the second edge registers the new C.
  - On the second edge: go to IDLE and set c_valid=1 for one cycle.
- c_valid is high in the first IDLE cycle after FIRE. The multiplier's C is then valid and stays held while enable stays low.
- A, B and matrix_size are stable from the last LOAD_B word until the next size word is accepted.
- A new size word may be accepted in the same cycle c_valid is high.
- s_valid low at any point simply stalls; counters hold and nothing is written.
- enable is registered: a registered output of the FSM, glitch-free.
- Latency: last B word accepted at edge E -> enable high in cycles E+1 and E+2 -> c_valid high in cycle E+3.

Optional Feature:
- Macro: MATRIX_LOADER_SIZE_ERR_EN.
- Defined:
  - Adds output port size_err (1 bit, reset 0).
  - A size word of 0 or >MAX_SIZE is rejected: it is accepted (s_ready handshake completes), size_err pulses for one cycle, and the FSM stays in IDLE with A, B and matrix_size unchanged.
- Undefined: no size_err port; out-of-range sizes are clamped as described in Behaviour.

Test Plan:
- Size 2, A=[1,2,3,4], B=[5,6,7,8], s_valid held high -> enable high for 2 cycles, c_valid one cycle later; multiplier C[0..3]=[19,22,43,50], all other C elements 0.
- Size 3 load with s_valid toggled randomly -> same A/B placement as the gap-free load (A[(r*10+c)*32] layout); enable not asserted before the 18th element is accepted.
- Size word 15 (no macro) -> matrix_size=10; 100+100 elements accepted; size word 0 -> matrix_size=1, 1+1 elements accepted.
- With MATRIX_LOADER_SIZE_ERR_EN: size word 0 -> size_err pulses, busy stays 0, previous A/B unchanged; next valid size word 2 loads normally.
- rst_n asserted after 3 of 4 A elements for size 2 -> A=B=0, state IDLE, no enable or c_valid; a subsequent full load produces the correct result.
- Back-to-back: second size word presented during the c_valid cycle -> accepted immediately; A/B cleared that edge; second result correct.
